// File: rtl/vram_dma_pkg.sv
// vram_dma_pkg: shared parameters for the VRAM DMA engine.
//   - default VRAM / source address widths
//   - CPU register map indices (cfg_addr values)
//   - CTRL register bit positions
//   - FSM state encoding
package vram_dma_pkg;

  localparam int VRAM_ADDR_WIDTH_DEF = 12;
  localparam int SRC_ADDR_WIDTH_DEF  = 16;
  localparam int LEN_WIDTH           = 16;

  // cfg_addr register indices
  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_LEN_LO = 3'd4;
  localparam logic [2:0] REG_LEN_HI = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;

  // CTRL bit positions (strobes, not stored)
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_CLR = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/vram_dma.sv
// vram_dma: copies LEN bytes from CPU-space source memory into GPU VRAM,
// writing VRAM only while the GPU reports it writable (vertical blank).
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   cfg_we/addr/wdata CPU register writes (SRC, DST, LEN, CTRL)
//   src_addr, src_rd  source read request (registered)
//   src_rdata         source data, valid the cycle after src_rd
//   writable          1 while VRAM may be written
//   vram_addr/wdata/we VRAM write port (registered, 1-cycle strobe per byte)
//   busy              transfer in progress
//   done_irq          sticky completion flag, cleared by CTRL IRQ_CLR
//   dbg_state         current FSM state
//
// Source interface: there is no ready/valid pair; src_rd is a request
// strobe and the source must present src_rdata exactly one cycle later,
// which is the cycle the FSM spends in WRITE.
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter int VRAM_ADDR_WIDTH = VRAM_ADDR_WIDTH_DEF,
  parameter int SRC_ADDR_WIDTH  = SRC_ADDR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_addr,
  input  logic [7:0]                 cfg_wdata,
  output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
  output logic                       src_rd,
  input  logic [7:0]                 src_rdata,
  input  logic                       writable,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]                 vram_wdata,
  output logic                       vram_we,
  output logic                       busy,
  output logic                       done_irq,
  output dma_state_e                 dbg_state
);

  dma_state_e state;

  // CPU-visible configuration (16-bit, truncated to the address widths)
  logic [15:0]          src_reg;
  logic [15:0]          dst_reg;
  logic [LEN_WIDTH-1:0] len_reg;

  // Working copies advanced as bytes are written
  logic [SRC_ADDR_WIDTH-1:0]  cur_src;
  logic [VRAM_ADDR_WIDTH-1:0] cur_dst;
  logic [LEN_WIDTH-1:0]       rem;
  logic [7:0]                 hold;

  logic       ctrl_wr;
  logic       start_req;
  logic       abort_req;
  logic       irq_clr;
  logic       write_fire;
  logic       last_byte;
  logic       set_done;
  logic [7:0] write_byte;

  always_comb begin
    ctrl_wr    = cfg_we && (cfg_addr == REG_CTRL);
    // ABORT in the same CTRL write as START cancels the start
    start_req  = ctrl_wr && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_ABORT] && !busy;
    abort_req  = ctrl_wr && cfg_wdata[CTRL_ABORT] && busy;
    irq_clr    = ctrl_wr && cfg_wdata[CTRL_IRQ_CLR];
    write_fire = ((state == ST_WRITE) || (state == ST_WAIT)) && writable;
    // In WRITE the byte is still on src_rdata; in WAIT it sits in hold
    write_byte = (state == ST_WRITE) ? src_rdata : hold;
    last_byte  = (rem == 16'd1);
    // A write coinciding with ABORT still lands, but never completes the job
    set_done   = (start_req && (len_reg == '0)) ||
                 (write_fire && last_byte && !abort_req);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
      src_rd     <= 1'b0;
      src_addr   <= '0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      cur_src    <= '0;
      cur_dst    <= '0;
      rem        <= '0;
      hold       <= '0;
    end else begin
      src_rd  <= 1'b0;
      vram_we <= 1'b0;

      if (cfg_we && !busy) begin
        case (cfg_addr)
          REG_SRC_LO: src_reg[7:0]  <= cfg_wdata;
          REG_SRC_HI: src_reg[15:8] <= cfg_wdata;
          REG_DST_LO: dst_reg[7:0]  <= cfg_wdata;
          REG_DST_HI: dst_reg[15:8] <= cfg_wdata;
          REG_LEN_LO: len_reg[7:0]  <= cfg_wdata;
          REG_LEN_HI: len_reg[15:8] <= cfg_wdata;
          default: ;
        endcase
      end

      // Set wins over clear
      if (set_done) begin
        done_irq <= 1'b1;
      end else if (irq_clr) begin
        done_irq <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_req && (len_reg != '0)) begin
            state    <= ST_READ;
            busy     <= 1'b1;
            cur_src  <= src_reg[SRC_ADDR_WIDTH-1:0];
            cur_dst  <= dst_reg[VRAM_ADDR_WIDTH-1:0];
            rem      <= len_reg;
            // src_rd is registered, so the request is issued on READ entry
            src_rd   <= 1'b1;
            src_addr <= src_reg[SRC_ADDR_WIDTH-1:0];
          end
        end
        ST_READ: begin
          state <= ST_WRITE;
        end
        ST_WRITE, ST_WAIT: begin
          if (state == ST_WRITE) begin
            hold <= src_rdata;
          end
          if (write_fire) begin
            vram_we    <= 1'b1;
            vram_addr  <= cur_dst;
            vram_wdata <= write_byte;
            cur_src    <= cur_src + SRC_ADDR_WIDTH'(1);
            cur_dst    <= cur_dst + VRAM_ADDR_WIDTH'(1);
            rem        <= rem - 16'd1;
            if (last_byte) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              // Issue the next read right away: 2 cycles per byte
              state    <= ST_READ;
              src_rd   <= 1'b1;
              src_addr <= cur_src + SRC_ADDR_WIDTH'(1);
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // ABORT overrides the next state; any write already decided above stands
      if (abort_req) begin
        state  <= ST_IDLE;
        busy   <= 1'b0;
        src_rd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_dma.sv
// Testbench for vram_dma: table of transfer vectors plus hand-written
// sequences for abort, reset mid-transfer, busy-ignore and IRQ_CLR races.
module tb_vram_dma;
  import vram_dma_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_rdata = 8'h00;
  logic        writable = 1'b1;
  logic [11:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        busy;
  logic        done_irq;
  dma_state_e  dbg_state;

  vram_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .src_addr   (src_addr),
    .src_rd     (src_rd),
    .src_rdata  (src_rdata),
    .writable   (writable),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .busy       (busy),
    .done_irq   (done_irq),
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int n_reads  = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  bit chk_spacing = 1'b0;
  int wr_mode = 0;        // 0: writable=1, 1: toggle every 5 cycles, 2: wr_manual
  logic wr_manual = 1'b1;
  int tog_cnt = 0;
  logic wr_prev = 1'b1;

  logic [19:0] exp_q[$];  // {vram_addr, vram_wdata}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Source memory: data appears one cycle after src_rd
  always @(posedge clk) begin
    cyc <= cyc + 1;
    wr_prev <= writable;
    if (src_rd) src_rdata <= mem_byte(src_addr);
  end

  // writable generator
  always @(posedge clk) begin
    #1;
    case (wr_mode)
      0: writable = 1'b1;
      1: begin
        if (tog_cnt == 4) begin
          tog_cnt = 0;
          writable = ~writable;
        end else begin
          tog_cnt++;
        end
      end
      default: writable = wr_manual;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (src_rd) n_reads++;
    if (vram_we) begin
      // vram_we is the registered result of a decision taken last cycle
      chk("we_gate", wr_prev, 1);
      if (chk_spacing && n_writes > 0) chk("spacing", cyc - last_we_cyc, 2);
      last_we_cyc = cyc;
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {vram_addr, vram_wdata}, 20'hFFFFF);
      end else begin
        chk("vram_write", {vram_addr, vram_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    cfg_wdata = 8'h00;
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    cfg_write(REG_SRC_LO, s[7:0]);
    cfg_write(REG_SRC_HI, s[15:8]);
    cfg_write(REG_DST_LO, d[7:0]);
    cfg_write(REG_DST_HI, d[15:8]);
    cfg_write(REG_LEN_LO, l[7:0]);
    cfg_write(REG_LEN_HI, l[15:8]);
  endtask

  task automatic push_exp(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] sa;
      logic [11:0] da;
      sa = s + 16'(i);
      da = d[11:0] + 12'(i);
      exp_q.push_back({da, mem_byte(sa)});
    end
  endtask

  task automatic clear_counts();
    n_writes = 0;
    n_reads = 0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("idle_timeout", busy, 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_writes >= n) break;
      @(posedge clk); #1;
    end
    chk("write_wait_timeout", (n_writes >= n), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          mode;
    bit          spacing;
    int          exp_writes;
    logic        exp_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0200, 16'h0010, 16'd4, 0, 1'b1, 4, 1'b1}; // basic, 2-cycle spacing
    vecs[1] = '{16'h1234, 16'h0100, 16'd3, 1, 1'b0, 3, 1'b1}; // writable toggling
    vecs[2] = '{16'h0300, 16'h0FFE, 16'd4, 0, 1'b0, 4, 1'b1}; // VRAM address wrap
    vecs[3] = '{16'hFFFE, 16'h0020, 16'd4, 0, 1'b1, 4, 1'b1}; // source address wrap
    vecs[4] = '{16'h0050, 16'h07F0, 16'd7, 1, 1'b0, 7, 1'b1}; // longer, gated
    vecs[5] = '{16'h0000, 16'h0000, 16'd0, 0, 1'b0, 0, 1'b1}; // zero length

    rst = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 3'd0;
    cfg_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done_irq, 0);
    chk("rst_src_rd", src_rd, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_wdata", vram_wdata, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // START straight after reset: LEN register is 0, so completes at once
    clear_counts();
    cfg_write(REG_CTRL, 8'h01);
    chk("len0_busy", busy, 0);
    chk("len0_done", done_irq, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("len0_reads", n_reads, 0);
    chk("len0_writes", n_writes, 0);

    // table
    for (int v = 0; v < 6; v++) begin
      cfg_write(REG_CTRL, 8'h04);
      chk("irq_clear", done_irq, 0);
      wr_mode = vecs[v].mode;
      program_regs(vecs[v].src, vecs[v].dst, vecs[v].len);
      clear_counts();
      chk_spacing = vecs[v].spacing;
      push_exp(vecs[v].src, vecs[v].dst, vecs[v].len);
      cfg_write(REG_CTRL, 8'h01);
      chk("start_busy", busy, (vecs[v].len != 0));
      wait_idle(400);
      chk_spacing = 1'b0;
      chk("vec_writes", n_writes, vecs[v].exp_writes);
      chk("vec_reads", n_reads, vecs[v].exp_writes);
      chk("vec_done", done_irq, vecs[v].exp_done);
      chk("vec_queue_empty", exp_q.size(), 0);
      exp_q.delete();
    end

    // ABORT after 2 bytes of LEN=10; it lands in byte 3's WRITE cycle,
    // so byte 3 still completes and nothing follows it.
    wr_mode = 0;
    cfg_write(REG_CTRL, 8'h04);
    program_regs(16'h0400, 16'h0200, 16'd10);
    clear_counts();
    push_exp(16'h0400, 16'h0200, 16'd10);
    cfg_write(REG_CTRL, 8'h01);
    wait_writes(2, 100);
    cfg_write(REG_CTRL, 8'h02);
    chk("abort_busy", busy, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_writes", n_writes, 3);
    chk("abort_reads", n_reads, 3);
    chk("abort_done", done_irq, 0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("abort_left", exp_q.size(), 7);
    exp_q.delete();

    // reset mid-transfer: no write from the reset cycle onward
    program_regs(16'h0500, 16'h0240, 16'd10);
    clear_counts();
    push_exp(16'h0500, 16'h0240, 16'd10);
    cfg_write(REG_CTRL, 8'h01);
    wait_writes(2, 100);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_we", vram_we, 0);
    chk("rstmid_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("rstmid_writes", n_writes, 2);
    chk("rstmid_done", done_irq, 0);
    chk("rstmid_busy2", busy, 0);
    chk("rstmid_left", exp_q.size(), 8);
    exp_q.delete();

    // cfg writes and START while busy are ignored; IRQ_CLR lands in the
    // cycle the 5th byte is written (start + 10 cycles)
    program_regs(16'h0700, 16'h0300, 16'd5);
    clear_counts();
    push_exp(16'h0700, 16'h0300, 16'd5);
    cfg_write(REG_CTRL, 8'h01);
    cfg_write(REG_SRC_LO, 8'hAA);
    cfg_write(REG_DST_LO, 8'h55);
    cfg_write(REG_LEN_LO, 8'h02);
    cfg_write(REG_CTRL, 8'h01);
    repeat (5) begin @(posedge clk); #1; end
    cfg_write(REG_CTRL, 8'h04);
    chk("race_busy", busy, 0);
    chk("race_done", done_irq, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("ign_writes", n_writes, 5);
    chk("ign_queue", exp_q.size(), 0);

    // rerun with the same registers: must repeat the original transfer
    cfg_write(REG_CTRL, 8'h04);
    chk("race_clear", done_irq, 0);
    clear_counts();
    push_exp(16'h0700, 16'h0300, 16'd5);
    cfg_write(REG_CTRL, 8'h01);
    wait_idle(100);
    chk("rerun_writes", n_writes, 5);
    chk("rerun_queue", exp_q.size(), 0);
    chk("rerun_done", done_irq, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
